// File: rtl/mmu_port_dma_if.sv
// Host request/data streams plus the memory_system MMU port, bundled for mmu_port_dma.
// Latency: wiring only, no storage.
// Backpressure: req_rdy/wr_rdy/rd_rdy handshakes travel on this bundle unchanged.
//
// Signals: req_* burst request, wr_* write stream, rd_* read stream, done/busy status,
//          mmu_mem_* second memory port (enb/web/addrb/dinb out, doutb in).
// modport master: the DMA block.  modport slave: the host and memory side.
interface mmu_port_dma_if;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wr;
    logic [13:0] req_addr;
    logic [7:0]  req_len;

    logic        wr_vld;
    logic        wr_rdy;
    logic [63:0] wr_data;

    logic        rd_vld;
    logic        rd_rdy;
    logic [63:0] rd_data;

    logic        done;
    logic        busy;

    logic        mmu_mem_enb;
    logic        mmu_mem_web;
    logic [13:0] mmu_mem_addrb;
    logic [63:0] mmu_mem_dinb;
    logic [63:0] mmu_mem_doutb;

    modport master (
        input  req_vld, req_wr, req_addr, req_len,
        input  wr_vld, wr_data,
        input  rd_rdy,
        input  mmu_mem_doutb,
        output req_rdy, wr_rdy, rd_vld, rd_data, done, busy,
        output mmu_mem_enb, mmu_mem_web, mmu_mem_addrb, mmu_mem_dinb
    );

    modport slave (
        output req_vld, req_wr, req_addr, req_len,
        output wr_vld, wr_data,
        output rd_rdy,
        output mmu_mem_doutb,
        input  req_rdy, wr_rdy, rd_vld, rd_data, done, busy,
        input  mmu_mem_enb, mmu_mem_web, mmu_mem_addrb, mmu_mem_dinb
    );
endinterface

// File: rtl/mmu_port_dma.sv
// mmu_port_dma: burst write/read master driving the MMU port of memory_system.
// Latency: write beat -> port write next cycle; read request accepted in cycle 0 -> rd_vld in cycle 4.
// Backpressure: wr_vld gaps idle the port; with rd_rdy low, issue stalls once buffered + in-flight reads reach RD_DEPTH.
//
// Ports: clk  - core clock, also clocks the memory port externally
//        rst  - asynchronous active-low reset
//        bus  - mmu_port_dma_if.master: req_*, wr_*, rd_*, done, busy, mmu_mem_*
module mmu_port_dma #(
    parameter int RD_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    mmu_port_dma_if.master bus
);
    localparam int PW = $clog2(RD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(RD_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t        state_q, state_d;

    logic [13:0]   cur_addr_q, cur_addr_d;
    logic [8:0]    remaining_q, remaining_d;
    logic [1:0]    inflight_q, inflight_d;
    logic          enb_q, enb_d;
    logic          web_q, web_d;
    logic [13:0]   addrb_q, addrb_d;
    logic [63:0]   dinb_q, dinb_d;
    logic          done_q, done_d;
    logic          rd_pend_q, rd_pend_d;

    logic [63:0]   fifo_q [RD_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] fifo_cnt_q;

    // Decoded per-cycle events
    logic          req_rdy_c;
    logic          wr_rdy_c;
    logic          accept;
    logic          beat;
    logic          issue;
    logic          push;
    logic          pop;
    logic          read_last;
    logic [CW:0]   credit_used;

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = bus.req_wr ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (beat && remaining_q == 9'd1) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (read_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM outputs and handshake decode
    // ---------------------------------------------------------------
    // Credits cover both words sitting in the buffer and reads still in
    // the enb/doutb pipe, so a push can never find the buffer full.
    assign credit_used = {1'b0, fifo_cnt_q} + (CW+1)'(inflight_q);

    always_comb begin
        req_rdy_c = 1'b0;
        wr_rdy_c  = 1'b0;
        issue     = 1'b0;
        case (state_q)
            S_IDLE:  req_rdy_c = rst;
            S_WRITE: wr_rdy_c  = 1'b1;
            S_READ:  issue     = (remaining_q != 9'd0) && (credit_used < DEPTH_C);
            default: begin
                req_rdy_c = 1'b0;
            end
        endcase
    end

    assign accept    = bus.req_vld & req_rdy_c;
    assign beat      = bus.wr_vld & wr_rdy_c;
    assign push      = rd_pend_q;
    assign pop       = (fifo_cnt_q != '0) & bus.rd_rdy;
    assign read_last = (state_q == S_READ) && (remaining_q == 9'd0) && (inflight_q == 2'd0)
                       && pop && (fifo_cnt_q == CW'(1));

    // ---------------------------------------------------------------
    // Datapath next state
    // ---------------------------------------------------------------
    always_comb begin
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        addrb_d     = addrb_q;
        dinb_d      = dinb_q;
        enb_d       = 1'b0;
        web_d       = 1'b0;
        done_d      = 1'b0;
        // A read seen on the port last cycle has its data on doutb now.
        rd_pend_d   = enb_q & ~web_q;

        case ({issue, push})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase

        if (accept) begin
            cur_addr_d  = bus.req_addr;
            remaining_d = {1'b0, bus.req_len} + 9'd1;
        end

        if (beat) begin
            enb_d       = 1'b1;
            web_d       = 1'b1;
            addrb_d     = cur_addr_q;
            dinb_d      = bus.wr_data;
            cur_addr_d  = cur_addr_q + 14'd1;
            remaining_d = remaining_q - 9'd1;
            done_d      = (remaining_q == 9'd1);
        end

        if (issue) begin
            enb_d       = 1'b1;
            web_d       = 1'b0;
            addrb_d     = cur_addr_q;
            cur_addr_d  = cur_addr_q + 14'd1;
            remaining_d = remaining_q - 9'd1;
        end

        if (read_last) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_addr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= '0;
            enb_q       <= 1'b0;
            web_q       <= 1'b0;
            addrb_q     <= '0;
            dinb_q      <= '0;
            done_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            enb_q       <= enb_d;
            web_q       <= web_d;
            addrb_q     <= addrb_d;
            dinb_q      <= dinb_d;
            done_q      <= done_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    // ---------------------------------------------------------------
    // Read return buffer
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= bus.mmu_mem_doutb;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.req_rdy       = req_rdy_c;
    assign bus.wr_rdy        = wr_rdy_c;
    assign bus.rd_vld        = (fifo_cnt_q != '0);
    assign bus.rd_data       = fifo_q[rd_ptr_q];
    assign bus.done          = done_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.mmu_mem_enb   = enb_q;
    assign bus.mmu_mem_web   = web_q;
    assign bus.mmu_mem_addrb = addrb_q;
    assign bus.mmu_mem_dinb  = dinb_q;

endmodule

// File: doc/mmu_port_dma.md
# mmu_port_dma

Block-transfer master for the second (MMU) port of `memory_system`. It accepts a host request to write or read a burst of 64-bit words and drives `mmu_mem_enb/web/addrb/dinb` to perform it. Read data from `mmu_mem_doutb` returns through a 4-entry buffer, so the host read stream can apply backpressure. It sits beside `top_level_wb`, on the opposite end of the `mmu_mem_*` port that the memory system exposes.

## Interface
Parameters:
- `RD_DEPTH`, 4: read return buffer entries. Fixed at 4; the credit logic depends on it.

Ports:
- `clk`  in  1  clock; also drives the memory's `mmu_mem_clk` externally.
- `rst`  in  1  asynchronous, active-low reset.
- `req_vld`  in  1  host request valid.
- `req_rdy`  out  1  block can accept a request.
- `req_wr`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  14  start word address.
- `req_len`  in  8  burst length minus 1 (1..256 words).
- `wr_vld`  in  1  host write data valid.
- `wr_rdy`  out  1  block accepts write data.
- `wr_data`  in  64  write word.
- `rd_vld`  out  1  read word valid.
- `rd_rdy`  in  1  host accepts read word.
- `rd_data`  out  64  read word.
- `done`  out  1  one-cycle pulse when a burst completes.
- `busy`  out  1  high in any state other than IDLE.
- `mmu_mem_enb`, `mmu_mem_web`  out  1 each  port enable and write enable (registered).
- `mmu_mem_addrb`  out  14  port address (registered).
- `mmu_mem_dinb`  out  64  port write data (registered).
- `mmu_mem_doutb`  in  64  port read data; valid the cycle after a read with `enb` high.

## Operation
- States:
  - **IDLE**: `req_rdy = rst`. On `req_vld & req_rdy`, latch `cur_addr = req_addr` and `remaining = req_len + 1` (9 bits). Go to WRITE if `req_wr` is 1, otherwise READ.
  - **WRITE**: `wr_rdy = 1`.
    - Each `wr_vld & wr_rdy` beat registers `enb=1`, `web=1`, `addrb=cur_addr`, `dinb=wr_data` for the next cycle. It then increments `cur_addr` and decrements `remaining`.
    - On the beat where `remaining` reaches 0, go to IDLE and pulse `done` the next cycle, coincident with the last port write.
  - **READ**: a read issues when `remaining != 0` and `fifo_cnt + inflight < 4`.
    - An issue registers `enb=1`, `web=0`, `addrb=cur_addr`, then increments `cur_addr` and decrements `remaining`.
    - `inflight` counts issued reads not yet pushed into the buffer. It ranges 0..2: the `enb` register stage plus the `doutb` stage.
    - The cycle after `enb` is seen high with `web=0`, `mmu_mem_doutb` is pushed into the buffer.
    - `rd_vld = fifo_cnt != 0`; `rd_data` is the buffer head.
    - When `remaining == 0`, `inflight == 0`, and the last word pops (`rd_vld & rd_rdy` with `fifo_cnt == 1`), pulse `done` the next cycle and go to IDLE.
- `enb` and `web` are 0 in any cycle without an issue or beat. `dinb` holds its last value.
- Address arithmetic is 14-bit modulo: 0x3FFF + 1 wraps to 0x0000.
- Buffer push and pop in the same cycle leave `fifo_cnt` unchanged. A push into a full buffer cannot occur under the credit rule. A bench assertion checks this.
- `busy = (state != IDLE)`. `wr_rdy` is 0 outside WRITE.
- Reset (asynchronous, any time including mid-burst):
  - state returns to IDLE; buffer, `inflight` and `remaining` clear.
  - `enb`, `web`, `done`, `rd_vld`, `wr_rdy`, `busy`, `req_rdy` are all 0 while `rst` is low.
  - `addrb`, `dinb` and `rd_data` reset to 0.
  - An in-flight memory read is discarded.

## Timing
- Request accepted at cycle 0 → WRITE or READ from cycle 1.
- Write: a beat accepted in cycle n → port write in cycle n+1. Sustains 1 word/cycle.
- Read, first word: issue in cycle 1, `enb` high in cycle 2, `doutb` valid in cycle 3, `rd_vld` in cycle 4.
- Read steady state: 1 word/cycle with `rd_rdy` held high.
- Read under backpressure: issue stalls once `fifo_cnt + inflight == 4`, and resumes the cycle after a pop frees a credit.
- `done` is high for exactly 1 cycle. `req_rdy` rises in the same cycle as `done`, so back-to-back requests lose one cycle.

## Test plan
- **Reset values:** assert `rst=0` mid-read with 2 words in flight → all outputs 0 in the same cycle. After release, `req_rdy=1` and the buffer is empty.
- **Write burst with wrap:** `req_addr=0x3FFE`, `req_len=2`, data A/B/C streamed back-to-back → port writes `(0x3FFE,A)`, `(0x3FFF,B)`, `(0x0000,C)` on consecutive cycles. `done` pulses with the C write.
- **Read streaming:** preload words 0x10..0x17 at addresses 0x100..0x107; `req_len=7`, `rd_rdy=1` → `rd_vld` first at cycle 4, then 8 consecutive words 0x10..0x17 in order. `done` follows the last pop.
- **Read backpressure:** same burst with `rd_rdy=0` for 10 cycles → at most 4 reads issued, no buffer overflow. After `rd_rdy=1`, data is still in order and complete.
- **Stalled write source:** `wr_vld` toggling 1,0,0,1,… → one port write per accepted beat only, `enb=0` on gap cycles, addresses contiguous.
- **Single word:** `req_len=0`, write then read → exactly 1 port access each. `done` at cycle 2 for the write; `done` the cycle after the pop for the read.
